// File: rtl/iddmm_mul_pipe_if.sv
// Operand/product handshake bundle for the IDDMM pipelined multiplier.
// The master drives operand pairs and consumes products; the slave is the multiplier.
interface iddmm_mul_pipe_if #(
    parameter int WIDTH = 128,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_x;
    logic [WIDTH-1:0]     in_y;
    logic                 in_low;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;
    logic                 out_low;
    logic [TAG_W-1:0]     out_tag;
    logic                 busy;

    modport master (
        output in_valid, in_x, in_y, in_low, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_low, out_tag, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_low, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_low, out_tag, busy
    );
endinterface

// File: rtl/iddmm_mul_pipe.sv
// Pipelined unsigned WIDTH x WIDTH multiplier with a global-stall valid/ready
// handshake, per-transaction low-half mode and a sideband tag.
// Stage 1 registers the LIMB x LIMB partial products, stage 2 folds them into
// two column-parity partial sums, the middle stages carry that sum pair, and
// the last stage performs the single carry-propagate add. With LATENCY = 2 the
// partial products are summed directly in the final stage.
// WIDTH must be a multiple of LIMB and the bus instance must be built with the
// same WIDTH and TAG_W as this module.
module iddmm_mul_pipe #(
    parameter int WIDTH   = 128,
    parameter int LIMB    = 32,
    parameter int LATENCY = 7,
    parameter int TAG_W   = 4
) (
    input  logic          clk,
    input  logic          rst,
    iddmm_mul_pipe_if.slave bus
);
    localparam int N   = WIDTH / LIMB;
    localparam int PW  = 2 * WIDTH;
    localparam int PPW = 2 * LIMB;

    logic               adv;
    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] low_p;
    logic [TAG_W-1:0]   tag_p [LATENCY];
    logic [PPW-1:0]     pp_p0 [N*N];
    logic [PW-1:0]      sum_even;
    logic [PW-1:0]      sum_odd;
    logic [PW-1:0]      prod_p;

    // Exact LIMB x LIMB product, zero-extended so no high bits are lost.
    function automatic logic [PPW-1:0] limb_mul(input logic [LIMB-1:0] a,
                                                input logic [LIMB-1:0] b);
        return PPW'(a) * PPW'(b);
    endfunction

    // Low mode keeps only the bottom WIDTH bits and zeroes the upper half.
    function automatic logic [PW-1:0] apply_mode(input logic [PW-1:0] p,
                                                 input logic          low);
        return low ? {{WIDTH{1'b0}}, p[WIDTH-1:0]} : p;
    endfunction

    // One global enable: everything moves unless the output is held.
    assign adv          = !(vld_p[LATENCY-1] && !bus.out_ready);
    assign bus.in_ready = adv;

    // Stage valid bits are the only state that reset touches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else if (adv) begin
            vld_p <= {vld_p[LATENCY-2:0], bus.in_valid};
        end
    end

    // Low flag and tag travel alongside the data of every stage.
    always_ff @(posedge clk) begin
        if (adv) begin
            low_p    <= {low_p[LATENCY-2:0], bus.in_low};
            tag_p[0] <= bus.in_tag;
            for (int k = 1; k < LATENCY; k++) begin
                tag_p[k] <= tag_p[k-1];
            end
        end
    end

    // ---- stage 1: operand split into limb partial products ----
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pp_p0[i*N+j] <= limb_mul(bus.in_x[i*LIMB +: LIMB],
                                             bus.in_y[j*LIMB +: LIMB]);
                end
            end
        end
    end

    // Fold the partial products into two sums split by column parity; each
    // sum is a subset of the true product so neither can exceed 2*WIDTH bits.
    always_comb begin
        sum_even = '0;
        sum_odd  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (((i + j) % 2) == 0) begin
                    sum_even = sum_even + (PW'(pp_p0[i*N+j]) << ((i + j) * LIMB));
                end else begin
                    sum_odd  = sum_odd  + (PW'(pp_p0[i*N+j]) << ((i + j) * LIMB));
                end
            end
        end
    end

    generate
        if (LATENCY == 2) begin : g_direct
            // ---- stage 2 (final): full reduction and mode select ----
            always_ff @(posedge clk) begin
                if (adv) begin
                    prod_p <= apply_mode(sum_even + sum_odd, low_p[LATENCY-2]);
                end
            end
        end else begin : g_tree
            localparam int M = LATENCY - 2;
            logic [PW-1:0] se_p [M];
            logic [PW-1:0] so_p [M];

            // ---- stages 2..LATENCY-1: parity sum pair and its delay line ----
            always_ff @(posedge clk) begin
                if (adv) begin
                    se_p[0] <= sum_even;
                    so_p[0] <= sum_odd;
                    for (int k = 1; k < M; k++) begin
                        se_p[k] <= se_p[k-1];
                        so_p[k] <= so_p[k-1];
                    end
                end
            end

            // ---- stage LATENCY: carry-propagate add and mode select ----
            always_ff @(posedge clk) begin
                if (adv) begin
                    prod_p <= apply_mode(se_p[M-1] + so_p[M-1], low_p[LATENCY-2]);
                end
            end
        end
    endgenerate

    // Outputs are masked by the last valid bit so reset clears them at once
    // without having to reset the wide data registers.
    assign bus.out_valid  = vld_p[LATENCY-1];
    assign bus.out_result = vld_p[LATENCY-1] ? prod_p : '0;
    assign bus.out_low    = vld_p[LATENCY-1] & low_p[LATENCY-1];
    assign bus.out_tag    = vld_p[LATENCY-1] ? tag_p[LATENCY-1] : '0;
    assign bus.busy       = |vld_p;
endmodule

// File: tb/tb_iddmm_mul_pipe.sv
// Self-checking bench for iddmm_mul_pipe: three configurations share one
// stimulus bus selected by 'sel'; directed table vectors, stall and reset
// sequences, and scoreboarded streaming with and without back-pressure.
module tb_iddmm_mul_pipe;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iddmm_mul_pipe_if #(.WIDTH(128), .TAG_W(TAG_W)) bus0 ();
    iddmm_mul_pipe_if #(.WIDTH(64),  .TAG_W(TAG_W)) bus1 ();
    iddmm_mul_pipe_if #(.WIDTH(256), .TAG_W(TAG_W)) bus2 ();

    iddmm_mul_pipe #(.WIDTH(128), .LIMB(32), .LATENCY(7),  .TAG_W(TAG_W))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    iddmm_mul_pipe #(.WIDTH(64),  .LIMB(16), .LATENCY(3),  .TAG_W(TAG_W))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    iddmm_mul_pipe #(.WIDTH(256), .LIMB(64), .LATENCY(10), .TAG_W(TAG_W))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int               sel;
    int               cur_w;
    int               cur_l;
    logic             d_valid;
    logic             d_ready;
    logic             d_low;
    logic [255:0]     d_x;
    logic [255:0]     d_y;
    logic [TAG_W-1:0] d_tag;

    assign bus0.in_valid  = d_valid && (sel == 0);
    assign bus0.in_x      = d_x[127:0];
    assign bus0.in_y      = d_y[127:0];
    assign bus0.in_low    = d_low;
    assign bus0.in_tag    = d_tag;
    assign bus0.out_ready = (sel == 0) ? d_ready : 1'b1;

    assign bus1.in_valid  = d_valid && (sel == 1);
    assign bus1.in_x      = d_x[63:0];
    assign bus1.in_y      = d_y[63:0];
    assign bus1.in_low    = d_low;
    assign bus1.in_tag    = d_tag;
    assign bus1.out_ready = (sel == 1) ? d_ready : 1'b1;

    assign bus2.in_valid  = d_valid && (sel == 2);
    assign bus2.in_x      = d_x;
    assign bus2.in_y      = d_y;
    assign bus2.in_low    = d_low;
    assign bus2.in_tag    = d_tag;
    assign bus2.out_ready = (sel == 2) ? d_ready : 1'b1;

    logic             o_valid;
    logic             o_in_ready;
    logic             o_low;
    logic             o_busy;
    logic [511:0]     o_result;
    logic [TAG_W-1:0] o_tag;

    always_comb begin
        o_valid    = bus0.out_valid;
        o_in_ready = bus0.in_ready;
        o_low      = bus0.out_low;
        o_busy     = bus0.busy;
        o_result   = {256'b0, bus0.out_result};
        o_tag      = bus0.out_tag;
        if (sel == 1) begin
            o_valid    = bus1.out_valid;
            o_in_ready = bus1.in_ready;
            o_low      = bus1.out_low;
            o_busy     = bus1.busy;
            o_result   = {384'b0, bus1.out_result};
            o_tag      = bus1.out_tag;
        end else if (sel == 2) begin
            o_valid    = bus2.out_valid;
            o_in_ready = bus2.in_ready;
            o_low      = bus2.out_low;
            o_busy     = bus2.busy;
            o_result   = bus2.out_result;
            o_tag      = bus2.out_tag;
        end
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [255:0] x;
        logic [255:0] y;
        logic         low;
        logic [3:0]   tag;
        logic [511:0] res;
    } vec_t;

    typedef struct {
        logic [511:0] res;
        logic [3:0]   tag;
        logic         low;
    } exp_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select_dut(input int k);
        sel = k;
        cur_w = (k == 0) ? 128 : (k == 1) ? 64 : 256;
        cur_l = (k == 0) ? 7 : (k == 1) ? 3 : 10;
    endtask

    function automatic logic [255:0] wmask();
        return (cur_w >= 256) ? {256{1'b1}} : ((256'd1 << cur_w) - 256'd1);
    endfunction

    function automatic logic [511:0] expect_of(input logic [255:0] x, input logic [255:0] y,
                                               input logic low);
        logic [511:0] p;
        p = {256'b0, x} * {256'b0, y};
        if (low) p = p & {256'b0, wmask()};
        return p;
    endfunction

    task automatic gen_item(input int k);
        logic [255:0] rx;
        logic [255:0] ry;
        for (int i = 0; i < 8; i++) begin
            rx[i*32 +: 32] = $urandom;
            ry[i*32 +: 32] = $urandom;
        end
        case ($urandom_range(7))
            0: rx = {256{1'b1}};
            1: ry = '0;
            2: begin rx = {256{1'b1}}; ry = {256{1'b1}}; end
            default: ;
        endcase
        d_x   = rx & wmask();
        d_y   = ry & wmask();
        d_low = 1'($urandom_range(1));
        d_tag = TAG_W'(k);
    endtask

    // Single isolated transaction on an empty pipeline; latency is counted in
    // cycles from the cycle the pair is presented to the cycle out_valid shows.
    task automatic run_one(input string nm, input logic [255:0] x, input logic [255:0] y,
                           input logic low, input logic [3:0] tag, input logic [511:0] res);
        int lat;
        d_x = x; d_y = y; d_low = low; d_tag = tag; d_valid = 1'b1; d_ready = 1'b1;
        tick();
        lat = 1;
        d_valid = 1'b0;
        while (!o_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, 512'(lat), 512'(cur_l));
        chk({nm, "_result"}, o_result, res);
        chk({nm, "_tag"}, 512'(o_tag), 512'(tag));
        chk({nm, "_low"}, 512'(o_low), 512'(low));
        tick();
    endtask

    task automatic stream(input string nm, input int n, input bit bp, input int max_cyc);
        exp_t         q[$];
        exp_t         e;
        int           sent = 0;
        int           got = 0;
        int           cyc = 0;
        int           last_cyc = -1;
        bit           acc;
        bit           stalled_prev = 1'b0;
        logic [511:0] pr = '0;
        logic [3:0]   pt = '0;
        logic         pl = 1'b0;
        gen_item(0);
        d_valid = (n > 0);
        while ((sent < n || q.size() != 0) && cyc < max_cyc) begin
            d_ready = bp ? 1'($urandom_range(1)) : 1'b1;
            #1;
            chk({nm, "_in_ready"}, 512'(o_in_ready), 512'(!(o_valid && !d_ready)));
            if (stalled_prev) begin
                chk({nm, "_hold_valid"}, 512'(o_valid), 512'd1);
                chk({nm, "_hold_result"}, o_result, pr);
                chk({nm, "_hold_tag"}, 512'(o_tag), 512'(pt));
                chk({nm, "_hold_low"}, 512'(o_low), 512'(pl));
            end
            if (o_valid && d_ready) begin
                chk({nm, "_expected_pending"}, 512'(q.size() != 0), 512'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk({nm, "_result"}, o_result, e.res);
                    chk({nm, "_tag"}, 512'(o_tag), 512'(e.tag));
                    chk({nm, "_low"}, 512'(o_low), 512'(e.low));
                    got++;
                    last_cyc = cyc;
                end
            end
            acc = d_valid && o_in_ready;
            if (acc) begin
                e.res = expect_of(d_x, d_y, d_low);
                e.tag = d_tag;
                e.low = d_low;
                q.push_back(e);
            end
            stalled_prev = o_valid && !d_ready;
            pr = o_result;
            pt = o_tag;
            pl = o_low;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < n) gen_item(sent);
                else d_valid = 1'b0;
            end
        end
        d_valid = 1'b0;
        d_ready = 1'b1;
        chk({nm, "_all_sent"}, 512'(sent), 512'(n));
        chk({nm, "_all_back"}, 512'(got), 512'(n));
        chk({nm, "_busy_idle"}, 512'(o_busy), 512'd0);
        if (!bp) chk({nm, "_last_cycle"}, 512'(last_cyc), 512'(n - 1 + cur_l));
    endtask

    task automatic sweep_edges(input string nm);
        logic [255:0] ones;
        logic [511:0] sq;
        ones = wmask();
        sq = (512'd1 << (2 * cur_w)) - (512'd1 << (cur_w + 1)) + 512'd1;
        run_one({nm, "_0x0"},     '0,     '0,     1'b0, 4'd1, '0);
        run_one({nm, "_0xones"},  '0,     ones,   1'b0, 4'd2, '0);
        run_one({nm, "_1x1"},     256'd1, 256'd1, 1'b0, 4'd3, 512'd1);
        run_one({nm, "_onesx1"},  ones,   256'd1, 1'b0, 4'd4, {256'b0, ones});
        run_one({nm, "_onesq"},   ones,   ones,   1'b0, 4'd5, sq);
        run_one({nm, "_onesq_lo"}, ones,  ones,   1'b1, 4'd6, 512'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ghosts;
        select_dut(0);
        d_valid = 1'b0; d_ready = 1'b1; d_low = 1'b0; d_x = '0; d_y = '0; d_tag = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 512'(o_valid), 512'd0);
        chk("reset_busy", 512'(o_busy), 512'd0);
        chk("reset_result", o_result, 512'd0);
        chk("reset_tag", 512'(o_tag), 512'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 512'(o_in_ready), 512'd1);
        tick();

        // Directed vectors for the 128-bit, 7-stage configuration.
        vt[0] = '{{128'b0, {128{1'b1}}}, {128'b0, {128{1'b1}}}, 1'b0, 4'd3,
                  {256'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h1}};
        vt[1] = '{256'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 256'd2, 1'b1, 4'd5,
                  512'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0002};
        vt[2] = '{256'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 256'd2, 1'b0, 4'd6,
                  512'h1_FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0002};
        vt[3] = '{256'd0, {128'b0, {128{1'b1}}}, 1'b0, 4'd0, 512'd0};
        vt[4] = '{256'd1, 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b0, 4'd9,
                  512'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321};
        vt[5] = '{256'h8000_0000_0000_0000_0000_0000_0000_0000,
                  256'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 4'd7, 512'd1 << 254};
        vt[6] = '{256'h8000_0000_0000_0000_0000_0000_0000_0000,
                  256'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 4'd8, 512'd0};
        vt[7] = '{256'h1_0000_0000_0000_0003, 256'h1_0000_0005, 1'b0, 4'd10,
                  512'h1_0000_0005_0000_0003_0000_000F};
        vt[8] = '{{128'b0, {128{1'b1}}}, {128'b0, {128{1'b1}}}, 1'b1, 4'd15, 512'd1};
        vt[9] = '{256'hFFFF_FFFF, 256'hFFFF_FFFF, 1'b0, 4'd11, 512'hFFFF_FFFE_0000_0001};
        for (int i = 0; i < 10; i++) begin
            run_one($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].low, vt[i].tag, vt[i].res);
        end

        // Stall sequence: A presented at t=0, B at t=1, output held t=7..9.
        d_ready = 1'b1; d_valid = 1'b1; d_low = 1'b0;
        d_x = 256'd1000; d_y = 256'd3; d_tag = 4'd1;
        tick();
        d_x = 256'd77; d_y = 256'd11; d_tag = 4'd2;
        tick();
        d_valid = 1'b0;
        repeat (5) tick();
        chk("stall_a_valid", 512'(o_valid), 512'd1);
        chk("stall_a_tag", 512'(o_tag), 512'd1);
        d_ready = 1'b0; d_valid = 1'b1; d_x = 256'd5; d_y = 256'd5; d_tag = 4'd9;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_in_ready", 512'(o_in_ready), 512'd0);
            chk("stall_hold_tag", 512'(o_tag), 512'd1);
            chk("stall_hold_result", o_result, 512'd3000);
            tick();
        end
        d_valid = 1'b0; d_ready = 1'b1;
        #1;
        chk("stall_release_tag", 512'(o_tag), 512'd1);
        tick();
        chk("stall_b_valid", 512'(o_valid), 512'd1);
        chk("stall_b_tag", 512'(o_tag), 512'd2);
        chk("stall_b_result", o_result, 512'd847);
        tick();
        ghosts = 0;
        for (int s = 0; s < 10; s++) begin
            if (o_valid) ghosts++;
            tick();
        end
        chk("stall_no_ghost", 512'(ghosts), 512'd0);
        chk("stall_busy_idle", 512'(o_busy), 512'd0);

        stream("stream", 100, 1'b0, 400);
        stream("backpressure", 300, 1'b1, 3000);

        // Reset with the pipeline full and stalled.
        d_ready = 1'b0; d_valid = 1'b1; d_low = 1'b0;
        for (int k = 0; k < 10; k++) begin
            d_x = 256'(k + 3); d_y = 256'(k + 7); d_tag = 4'(k + 1);
            tick();
        end
        chk("rst_pre_valid", 512'(o_valid), 512'd1);
        chk("rst_pre_busy", 512'(o_busy), 512'd1);
        chk("rst_pre_tag", 512'(o_tag), 512'd1);
        chk("rst_pre_result", o_result, 512'd21);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 512'(o_valid), 512'd0);
        chk("rst_async_busy", 512'(o_busy), 512'd0);
        chk("rst_async_result", o_result, 512'd0);
        chk("rst_async_tag", 512'(o_tag), 512'd0);
        chk("rst_async_low", 512'(o_low), 512'd0);
        d_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        d_ready = 1'b1;
        #1;
        chk("rst_release_in_ready", 512'(o_in_ready), 512'd1);
        ghosts = 0;
        for (int s = 0; s < 15; s++) begin
            tick();
            if (o_valid) ghosts++;
        end
        chk("rst_no_stale", 512'(ghosts), 512'd0);
        run_one("rst_first", vt[7].x, vt[7].y, vt[7].low, vt[7].tag, vt[7].res);

        // Parameter sweep configurations.
        select_dut(1);
        sweep_edges("w64");
        stream("w64_rand", 1000, 1'b0, 1500);
        select_dut(2);
        sweep_edges("w256");
        stream("w256_rand", 1000, 1'b0, 1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iddmm_mul_pipe.md
# iddmm_mul_pipe

Parametrised, pipelined unsigned multiplier with valid/ready flow control, per-transaction output mode and a sideband tag. It generalises the fixed 128x128 multipliers: the same core supports full-width (2W) and low-half (W) products, and it stalls under back-pressure. It sits between the IDDMM Montgomery datapath controller, which issues operand pairs, and the reduction stage, which consumes products.

## Interface
- WIDTH, 128: operand width W in bits; legal range 8..1024.
- LIMB, 32: limb width used to split partial products; WIDTH must be a multiple of LIMB.
- LATENCY, 7: pipeline depth in register stages, input accept to output valid; legal range 2..16.
- TAG_W, 4: sideband tag width.

- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the operand pair this cycle.
- in_x  in  WIDTH  multiplicand, unsigned.
- in_y  in  WIDTH  multiplier, unsigned.
- in_low  in  1  1: return the low W bits only; 0: return the full 2W-bit product.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- out_result  out  2*WIDTH  product. In low mode, bits [2W-1:W] are zero.
- out_low  out  1  echo of in_low.
- out_tag  out  TAG_W  echo of in_tag.
- busy  out  1  OR of all stage valid bits.

## Operation
- Accept: a transfer occurs when in_valid && in_ready.
- Product: P = in_x * in_y, exact to 2W bits with no truncation. If in_low = 1, out_result = {W'b0, P[W-1:0]}.
- Datapath structure:
  - Stage 1 registers the operands and forms the (W/LIMB)^2 LIMB x LIMB partial products.
  - The remaining stages form a registered adder tree or carry-save compression, with a final carry-propagate add in the last stage.
  - The split of work across stages is implementation choice, provided total depth = LATENCY.
- Each stage carries a valid bit, the low flag and the tag alongside its data.
- Flow control uses a global stall:
  - stall = out_valid && !out_ready.
  - When stalled, every stage holds.
  - in_ready = !stall.
  - Bubbles are not compressed: empty stages advance like full ones whenever there is no stall.
- Ordering: results leave in acceptance order. No reordering, no drops, no duplication.
- Reset, asserted at any time:
  - All stage valid bits clear asynchronously.
  - out_valid = 0, out_result = 0, out_low = 0, out_tag = 0, busy = 0.
  - in_ready = 1 once rst is deasserted.
  - In-flight transactions are discarded and not completed after reset.

## Timing
- Latency: an operand pair accepted at edge N appears with out_valid = 1 after edge N+LATENCY, provided no stall occurs in between. Each stalled cycle adds exactly one cycle.
- Throughput: one transaction per cycle while out_ready = 1.
- in_ready is combinational from out_valid and out_ready only. There is no combinational path from in_valid to in_ready.
- Output hold: while out_valid && !out_ready, out_result, out_low and out_tag hold stable.
- Simultaneous events: when the pipeline is full, out_ready = 1 and in_valid = 1 in the same cycle, the output retires and the input is accepted on the same edge.
- Inputs are ignored whenever in_ready = 0, and in_x, in_y, in_low and in_tag are not sampled in that case.
- busy is registered-derived and deasserts on the edge at which the last valid stage empties.

## Test plan
1. Directed values, full mode, default parameters:
   - x = 2^128-1, y = 2^128-1, tag = 3 -> out_result = 2^256 - 2^129 + 1 and out_tag = 3, exactly 7 cycles after accept.
2. Low mode:
   - x = 0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, y = 2, in_low = 1 -> out_result = 0x...FFFE_0000_0000_0000_0002 low 128 bits, with upper 128 bits zero.
3. Streaming:
   - 100 back-to-back random pairs with mixed in_low and incrementing tags, out_ready held at 1 -> one result per cycle, in order, each matching a scoreboard of x*y.
4. Back-pressure:
   - Random out_ready with 50% duty under continuous in_valid -> no loss, no duplication, outputs stable while stalled, and in_ready = !(out_valid && !out_ready) every cycle.
5. Reset mid-operation:
   - Assert rst with 5 transactions in flight -> out_valid and busy drop immediately (asynchronously), all outputs read 0, and no stale result emerges after release.
   - The first transaction accepted after release completes after LATENCY cycles.
6. Parameter sweep:
   - WIDTH = 64, LIMB = 16, LATENCY = 3 and WIDTH = 256, LIMB = 64, LATENCY = 10 -> edge operands (0, 1, all-ones) and 1000 random pairs match the exact product at the configured latency.
